// File: rtl/mem_burst_if.sv
// ---------------------------------------------------------------------------
// mem_burst_if
//   Bundles the client request/stream signals and the mainMem pin signals
//   that connect to mem_burst_initiator.
//
//   Client side : req_valid/req_ready/req_wr/req_addr/req_size,
//                 wdata/wdata_req, rdata/rdata_valid/rdata_last, done, err
//   Memory side : mem_addr, mem_data_in, mem_data_out, mem_acc_size,
//                 mem_wren, mem_busy, mem_enable
//
//   Modports:
//     master - the initiator (drives memory pins and client responses)
//     slave  - the environment (client + memory)
// ---------------------------------------------------------------------------
interface mem_burst_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] wdata;
   logic        wdata_req;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        rdata_last;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic [1:0]  mem_acc_size;
   logic        mem_wren;
   logic        mem_busy;
   logic        mem_enable;

   modport master (
      input  req_valid, req_wr, req_addr, req_size, wdata, mem_data_out, mem_busy,
      output req_ready, wdata_req, rdata, rdata_valid, rdata_last, done, err,
             mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_size, wdata, mem_data_out, mem_busy,
      input  req_ready, wdata_req, rdata, rdata_valid, rdata_last, done, err,
             mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );
endinterface

// File: rtl/mem_burst_initiator.sv
// ---------------------------------------------------------------------------
// mem_burst_initiator
//   Accepts one single-word or burst (4/8/16 words) read/write request at a
//   time and drives the mainMem pins. Write data is pulled from the client
//   one word per cycle; read data is captured at the fixed memory read
//   latency and streamed back on rdata.
//
//   Parameters:
//     READ_LATENCY  - cycles from first request cycle on the pins to word 0
//                     valid on mem_data_out (>= 1)
//     START_ADDRESS - mem_addr value after reset
//
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous, active-high
//     bus   - mem_burst_if.master (client handshake + memory pins)
//
//   Optional build macro:
//     ADDR_ALIGN_CHECK_EN - also reject bursts not aligned to N*4 bytes
// ---------------------------------------------------------------------------
module mem_burst_initiator #(
   parameter int unsigned READ_LATENCY  = 2,
   parameter logic [31:0] START_ADDRESS = 32'h8002_0000
) (
   input logic         clock,
   input logic         reset,
   mem_burst_if.master bus
);

   typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DATA} state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        accept, reject, finish, sample, wreq, misaligned;
   logic [15:0] nwords;

   function automatic logic [15:0] burst_words(input logic [1:0] size);
      case (size)
         2'b00:   return 16'd1;
         2'b01:   return 16'd4;
         2'b10:   return 16'd8;
         default: return 16'd16;
      endcase
   endfunction

   // mem_acc_size doubles as the latched request size for the burst.
   assign nwords = burst_words(bus.mem_acc_size);

`ifdef ADDR_ALIGN_CHECK_EN
   always_comb begin
      logic [31:0] mask;
      mask       = {burst_words(bus.req_size), 2'b00} - 32'd1;
      misaligned = (bus.req_addr & mask) != 32'd0;
   end
`else
   assign misaligned = bus.req_addr[1:0] != 2'b00;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      accept        = 1'b0;
      reject        = 1'b0;
      finish        = 1'b0;
      sample        = 1'b0;
      wreq          = 1'b0;
      bus.req_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = !bus.mem_busy && !reset;
            if (bus.req_valid && bus.req_ready) begin
               cnt_nxt = '0;
               if (misaligned) begin
                  reject = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = bus.req_wr ? WRITE : READ_WAIT;
               end
            end
         end
         // cnt = 0 in T1; words pulled while cnt < N, one drain cycle at cnt = N
         WRITE: begin
            wreq    = (cnt < nwords) && !reset;
            cnt_nxt = cnt + 16'd1;
            if (cnt == nwords) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         READ_WAIT: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == 16'(READ_LATENCY - 1)) begin
               cnt_nxt   = '0;
               state_nxt = READ_DATA;
            end
         end
         READ_DATA: begin
            sample  = 1'b1;
            cnt_nxt = cnt + 16'd1;
            if (cnt == nwords - 16'd1) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.wdata_req = wreq;

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.rdata        <= '0;
         bus.rdata_valid  <= 1'b0;
         bus.rdata_last   <= 1'b0;
         bus.done         <= 1'b0;
         bus.err          <= 1'b0;
         bus.mem_addr     <= START_ADDRESS;
         bus.mem_data_in  <= '0;
         bus.mem_acc_size <= 2'b00;
         bus.mem_wren     <= 1'b0;
         bus.mem_enable   <= 1'b0;
      end else begin
         bus.mem_enable  <= 1'b1;
         bus.err         <= reject;
         bus.done        <= finish;
         bus.rdata_valid <= sample;
         bus.rdata_last  <= sample && finish;
         // wren trails wdata_req by one cycle, matching the data register
         bus.mem_wren    <= wreq;
         // rejected requests leave the memory pins untouched
         if (accept) begin
            bus.mem_addr     <= bus.req_addr;
            bus.mem_acc_size <= bus.req_size;
         end
         if (wreq)   bus.mem_data_in <= bus.wdata;
         if (sample) bus.rdata       <= bus.mem_data_out;
      end
   end

endmodule

// File: tb/tb_mem_burst_initiator.sv
module tb_mem_burst_initiator;
   localparam int RL = 2;
   localparam logic [31:0] START = 32'h8002_0000;
`ifdef ADDR_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_burst_if bus();
   mem_burst_initiator #(.READ_LATENCY(RL), .START_ADDRESS(START)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] base;    // word k = base*(k+1)
      logic        err;     // expected rejection
      int          done_t;  // expected done cycle Tn (0 = none)
   } vec_t;

   vec_t vecs[10];
   int total = 0;
   int bad = 0;
   logic [31:0] last_addr;
   logic [31:0] shadow [logic [31:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dw(input logic [31:0] b, input int k);
      return b * 32'(k + 1);
   endfunction

   function automatic int nw(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 4 : (s == 2'd2) ? 8 : 16;
   endfunction

   task automatic run_txn(input vec_t v, input int busy);
      int n;
      logic [31:0] a;
      logic e_wreq, e_wren, e_err, e_done, e_rv, e_rl;
      n = nw(v.size);
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_wr = v.wr; bus.req_addr = v.addr; bus.req_size = v.size;
      for (int b = 0; b < busy; b++) begin
         bus.mem_busy = 1'b1; #1;
         chk("busy_ready", bus.req_ready, 0);
         chk("busy_wren", bus.mem_wren, 0);
         chk("busy_addr", bus.mem_addr, last_addr);
         @(negedge clock);
      end
      bus.mem_busy = 1'b0; #1;
      chk("accept_ready", bus.req_ready, 1);
      @(negedge clock);
      bus.req_valid = 1'b0;
      for (int t = 1; t <= 24; t++) begin
         e_wreq = v.wr && !v.err && t <= n;
         e_wren = v.wr && !v.err && t >= 2 && t <= n + 1;
         e_err  = v.err && t == 1;
         e_done = (t == v.done_t);
         e_rv   = !v.wr && !v.err && t >= RL + 2 && t <= RL + n + 1;
         e_rl   = e_rv && t == RL + n + 1;
         chk("ctl{wreq,wren,err,done,rv,rl}",
             {26'd0, bus.wdata_req, bus.mem_wren, bus.err, bus.done, bus.rdata_valid, bus.rdata_last},
             {26'd0, e_wreq, e_wren, e_err, e_done, e_rv, e_rl});
         if (e_wren) begin
            chk("wr_data", bus.mem_data_in, dw(v.base, t - 2));
            chk("wr_addr", bus.mem_addr, v.addr);
            chk("wr_size", {30'd0, bus.mem_acc_size}, {30'd0, v.size});
         end
         if (!v.wr && !v.err && t <= RL + n) begin
            chk("rd_addr", bus.mem_addr, v.addr);
            chk("rd_size", {30'd0, bus.mem_acc_size}, {30'd0, v.size});
            chk("rd_wren", bus.mem_wren, 0);
         end
         if (e_rv) chk("rd_data", bus.rdata, dw(v.base, t - RL - 2));
         if (v.err && t == 1) chk("rej_addr", bus.mem_addr, last_addr);
         if (v.err && t == 2) chk("rej_ready", bus.req_ready, 1);
         bus.wdata = bus.wdata_req ? dw(v.base, t - 1) : 32'hFFFF_FFFF;
         a = v.addr + 32'(4 * (t - 1 - RL));
         if (!v.wr && t >= 1 + RL && t <= RL + n)
            bus.mem_data_out = shadow.exists(a) ? shadow[a] : 32'h0;
         else
            bus.mem_data_out = 32'hBAD0_0000 | 32'(t);
         @(negedge clock);
      end
      if (!v.err) begin
         last_addr = v.addr;
         if (v.wr) for (int k = 0; k < n; k++) shadow[v.addr + 32'(4 * k)] = dw(v.base, k);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h8002_0000, 2'd0, 32'h27BD_FFE8, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h8002_0000, 2'd0, 32'h27BD_FFE8, 1'b0, 4};
      vecs[2] = '{1'b1, 32'h8002_0004, 2'd1, 32'h1111_1111, ALIGN, ALIGN ? 0 : 6};
      vecs[3] = '{1'b0, 32'h8002_0004, 2'd1, 32'h1111_1111, ALIGN, ALIGN ? 0 : 7};
      vecs[4] = '{1'b1, 32'h8002_0040, 2'd3, 32'h0101_0101, 1'b0, 18};
      vecs[5] = '{1'b0, 32'h8002_0040, 2'd3, 32'h0101_0101, 1'b0, 19};
      vecs[6] = '{1'b1, 32'h8002_0002, 2'd0, 32'h5555_0000, 1'b1, 0};
      vecs[7] = '{1'b0, 32'h8002_0013, 2'd1, 32'h6666_0000, 1'b1, 0};
      vecs[8] = '{1'b1, 32'h8002_0010, 2'd2, 32'hA500_0001, ALIGN, ALIGN ? 0 : 10};
      vecs[9] = '{1'b0, 32'h8002_0010, 2'd2, 32'hA500_0001, ALIGN, ALIGN ? 0 : 11};

      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_size = '0;
      bus.wdata = '0; bus.mem_data_out = '0; bus.mem_busy = 1'b0;
      last_addr = START;

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ctl{ready,wreq,rv,rl,done,err,wren,en}",
          {24'd0, bus.req_ready, bus.wdata_req, bus.rdata_valid, bus.rdata_last,
           bus.done, bus.err, bus.mem_wren, bus.mem_enable}, 32'd0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_addr", bus.mem_addr, START);
      chk("rst_din", bus.mem_data_in, 0);
      chk("rst_size", {30'd0, bus.mem_acc_size}, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_enable", bus.mem_enable, 1);
      chk("post_rst_ready", bus.req_ready, 1);

      for (int i = 0; i < 10; i++) run_txn(vecs[i], 0);

      // busy holds off acceptance, then the read goes through
      run_txn(vecs[1], 3);

      // reset in the 3rd cycle of a 16-word write
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 32'h8002_0080; bus.req_size = 2'd3;
      bus.wdata = 32'h0;
      #1 chk("mid_accept", bus.req_ready, 1);
      @(negedge clock);             // T1
      bus.req_valid = 1'b0;
      @(negedge clock);             // T2
      chk("mid_wreq_t2", bus.wdata_req, 1);
      chk("mid_wren_t2", bus.mem_wren, 1);
      @(negedge clock);             // T3
      reset = 1'b1;
      #1 chk("mid_wreq_drop", bus.wdata_req, 0);
      @(negedge clock);             // T4
      chk("mid_rst_ctl{ready,wreq,rv,rl,done,err,wren,en}",
          {24'd0, bus.req_ready, bus.wdata_req, bus.rdata_valid, bus.rdata_last,
           bus.done, bus.err, bus.mem_wren, bus.mem_enable}, 32'd0);
      chk("mid_rst_addr", bus.mem_addr, START);
      chk("mid_rst_din", bus.mem_data_in, 0);
      chk("mid_rst_size", {30'd0, bus.mem_acc_size}, 0);
      reset = 1'b0;
      last_addr = START;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         chk("mid_no_done", {31'd0, bus.done}, 0);
         chk("mid_no_wren", {31'd0, bus.mem_wren}, 0);
      end
      chk("mid_enable", bus.mem_enable, 1);
      run_txn(vecs[0], 0);
      run_txn(vecs[1], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
